// File: rtl/button_conditioner_pkg.sv
// Shared FSM encoding and debounce constants for the button conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int STABLE_TICKS_SIM   = 4;
    localparam int STABLE_TICKS_BOARD = 1_000_000;

    // Stability counter width: max(1, clog2(ticks)).
    function automatic int cnt_width(input int ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Debouncer for one button: 2-flop synchroniser feeding a four-state qualify FSM.
// Latency: press/level rise (or level falls) STABLE_TICKS+3 edges after a clean raw change.
// Backpressure: none; press is a one-cycle pulse, dropped when press_en is low on acceptance.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic press_en,
    output logic level,
    output logic press
);

    localparam int              CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;

        // Only sync2_q is safe to use: sync1_q may still be metastable.
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    press_d = press_en;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button debouncer; one independent debounce_channel per button.
// Latency: STABLE_TICKS+3 edges from a clean raw change to level/press.
// Backpressure: none; press pulses are suppressed (not deferred) while enable is low.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int STABLE_TICKS = STABLE_TICKS_SIM
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_buttons,
    input  logic                enable,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw_buttons[i]),
            .press_en (enable),
            .level    (level[i]),
            .press    (press[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent button channels.
REQ-002 Parameter STABLE_TICKS, default 4: consecutive stable synchronised samples needed to accept a level change. The 50 MHz / 20 ms board value is 1_000_000; 4 is the simulation value.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 raw_buttons  input  CHANNELS  asynchronous raw button levels, 1 = pressed.
REQ-006 enable  input  1  when 0, press pulses are suppressed; debouncing continues.
REQ-007 level  output  CHANNELS  registered debounced button level per channel.
REQ-008 press  output  CHANNELS  registered one-cycle pulse per accepted press (0->1 debounced transition).

Function
REQ-009 Each channel SHALL pass raw_buttons[i] through a two-flop synchroniser; only the second flop output (s) SHALL feed that channel's FSM.
REQ-010 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT and a counter cnt of width max(1, clog2(STABLE_TICKS)).
REQ-011 IDLE: s=1 -> PRESS_WAIT with cnt=0; otherwise stay in IDLE.
REQ-012 PRESS_WAIT, s=0 -> IDLE, no pulse.
REQ-013 PRESS_WAIT, s=1 and cnt=STABLE_TICKS-1 -> HELD; otherwise cnt increments.
REQ-014 RELEASE_WAIT: s mirrors PRESS_WAIT. s=1 -> HELD, no pulse. s=0 and cnt=STABLE_TICKS-1 -> IDLE; otherwise cnt increments.
REQ-015 HELD: s=0 -> RELEASE_WAIT with cnt=0; otherwise stay in HELD.
REQ-016 level[i] SHALL be 1 exactly while the FSM is in HELD or RELEASE_WAIT.
REQ-017 press[i] SHALL be 1 for exactly one cycle: the cycle after the edge on which PRESS_WAIT->HELD occurs, and only if enable=1 on that edge.
REQ-018 A release, or a RELEASE_WAIT->HELD bounce, SHALL never assert press.
REQ-019 Latency: a clean raw rise SHALL give press/level high after the (STABLE_TICKS+3)th rising edge following the rise. A clean raw fall SHALL give level low after the (STABLE_TICKS+3)th edge.
REQ-020 Any raw pulse or gap shorter than STABLE_TICKS synchronised samples SHALL not change level.
REQ-021 Simultaneous presses on several channels SHALL each pulse in the same cycle; channels SHALL not interact.
REQ-022 Holding a button indefinitely SHALL produce exactly one press pulse; cnt SHALL not wrap in HELD or IDLE.
REQ-023 enable toggling SHALL affect only press, never FSM state or level. A press accepted while enable=0 SHALL be lost, not deferred.

Reset
REQ-024 While rst=1 at a rising edge: synchroniser flops, cnt and press SHALL become 0, the FSM SHALL enter IDLE and level SHALL become 0, for every channel.
REQ-025 Reset mid-debounce, including in HELD with the button still pressed, SHALL discard progress. After release of rst, a still-pressed button SHALL be re-qualified and SHALL produce one new press per REQ-019.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (2-bit) and the constants STABLE_TICKS_SIM=4 and STABLE_TICKS_BOARD=1_000_000.
REQ-027 One sub-module, debounce_channel (synchroniser, FSM, cnt, level, press for one bit), SHALL be instantiated CHANNELS times in a generate loop. The top SHALL contain only the loop and enable gating.
REQ-028 press outputs SHALL be directly compatible with button_press_counter increment inputs: one increment per physical press.

Verification
REQ-029 rst then raw_buttons=3'b001 held 20 cycles (STABLE_TICKS=4): press[0] high only in the cycle after edge 7; level[0]=1 from then on; press[2:1]=0 throughout.
REQ-030 raw_buttons[1] high for 3 cycles then low: level[1] and press[1] stay 0 throughout.
REQ-031 In HELD, raw_buttons[0] low for 2 cycles then high: level[0] stays 1 and no press. Then low for 10 cycles: level[0]=0 after edge 7 of the fall.
REQ-032 raw_buttons=3'b111 in one cycle: press=3'b111 in a single common cycle, then 3'b000.
REQ-033 enable=0 across the acceptance edge: level[2] rises and press[2] never asserts. Re-press with enable=1: one pulse.
REQ-034 rst=1 for 1 cycle while channel 0 is HELD and raw still high: level=0 and press=0 the next cycle, then exactly one new press on edge 7 after rst deasserts.
